// File: rtl/led_seq_ctrl_if.sv
// Board-side signal bundle for the LED sequencer: enable/key in, LED drive and status out.
// key_evt is a single-cycle strobe with no back-pressure; a consumer must sample it every cycle.
interface led_seq_ctrl_if #(
  parameter int LED_W  = 3,
  parameter int STEP_W = 2
);
  logic              en;
  logic              key;
  logic [LED_W-1:0]  led;
  logic [STEP_W-1:0] step_idx;
  logic              busy;
  logic              paused;
  logic              key_evt;
  logic [1:0]        dbg_state;

  modport master (
    output en, key,
    input  led, step_idx, busy, paused, key_evt, dbg_state
  );

  modport slave (
    input  en, key,
    output led, step_idx, busy, paused, key_evt, dbg_state
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED step sequencer: synchronised and debounced push-button drives IDLE/RUN/PAUSE,
// steps advance on a prescaled tick, and PAUSE blinks the held step.
module led_seq_ctrl #(
  parameter int CLK_DIV     = 50000,
  parameter int DWELL_TICKS = 100,
  parameter int DEB_TICKS   = 20,
  parameter int BLINK_TICKS = 25,
  parameter int NUM_STEPS   = 4,
  parameter int LED_W       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  led_seq_ctrl_if.slave bus
);
  localparam int STEP_W  = (NUM_STEPS   > 1) ? $clog2(NUM_STEPS)   : 1;
  localparam int PRE_W   = (CLK_DIV     > 1) ? $clog2(CLK_DIV)     : 1;
  localparam int DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int DEB_W   = (DEB_TICKS   > 1) ? $clog2(DEB_TICKS)   : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic                r_sync1, r_sync2;
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic                r_deb_level;
  logic [STEP_W-1:0]   r_step;
  logic [DWELL_W-1:0]  r_dwell;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_phase;
  logic [LED_W-1:0]    r_led;
  logic [STEP_W-1:0]   r_step_out;
  logic                r_busy, r_paused, r_key_evt;
  logic                w_tick, w_flip, w_press;
  logic [LED_W-1:0]    w_led;
  logic                w_busy, w_paused;
  logic [STEP_W-1:0]   w_step_inc;

  assign w_tick     = (r_pre_cnt == PRE_W'(CLK_DIV - 1));
  assign w_flip     = w_tick && (r_sync2 != r_deb_level) && (r_deb_cnt == DEB_W'(DEB_TICKS - 1));
  // The FSM acts on the accepting tick itself so a press can coincide with a dwell expiry.
  assign w_press    = w_flip && r_sync2;
  assign w_step_inc = (r_step == STEP_W'(NUM_STEPS - 1)) ? '0 : r_step + STEP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_pre_cnt   <= '0;
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b0;
    end else begin
      r_sync1   <= bus.key;
      r_sync2   <= r_sync1;
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
      if (w_tick) begin
        if (r_sync2 == r_deb_level) begin
          r_deb_cnt <= '0;
        end else if (w_flip) begin
          r_deb_cnt   <= '0;
          r_deb_level <= r_sync2;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (!bus.en) begin
      w_state_nx = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_press) w_state_nx = S_RUN;
        S_RUN:   if (w_press) w_state_nx = S_PAUSE;
        S_PAUSE: if (w_press) w_state_nx = S_RUN;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Dwell position survives PAUSE so a resume finishes the interrupted step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step        <= '0;
      r_dwell       <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!bus.en) begin
      r_step  <= '0;
      r_dwell <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_step  <= '0;
            r_dwell <= '0;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            if (r_dwell == DWELL_W'(DWELL_TICKS - 1)) begin
              r_dwell <= '0;
              r_step  <= w_step_inc;
            end else begin
              r_dwell <= r_dwell + DWELL_W'(1);
            end
          end
          if (w_press) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (w_tick) begin
            if (r_blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
              r_blink_cnt   <= '0;
              r_blink_phase <= ~r_blink_phase;
            end else begin
              r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_led    = '0;
    w_busy   = 1'b0;
    w_paused = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_led  = LED_W'(r_step);
        w_busy = 1'b1;
      end
      S_PAUSE: begin
        w_led    = r_blink_phase ? LED_W'(r_step) : '0;
        w_paused = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led      <= '0;
      r_step_out <= '0;
      r_busy     <= 1'b0;
      r_paused   <= 1'b0;
      r_key_evt  <= 1'b0;
    end else begin
      r_led      <= w_led;
      r_step_out <= r_step;
      r_busy     <= w_busy;
      r_paused   <= w_paused;
      r_key_evt  <= w_press;
    end
  end

  assign bus.led       = r_led;
  assign bus.step_idx  = r_step_out;
  assign bus.busy      = r_busy;
  assign bus.paused    = r_paused;
  assign bus.key_evt   = r_key_evt;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus random key/enable traffic against a
// tick-counting reference model with a per-cycle expected-output queue.
module tb_led_seq_ctrl;
  localparam int CLK_DIV     = 4;
  localparam int DWELL_TICKS = 3;
  localparam int DEB_TICKS   = 2;
  localparam int BLINK_TICKS = 2;
  localparam int NUM_STEPS   = 4;
  localparam int LED_W       = 3;
  localparam int STEP_W      = 2;
  localparam int OW          = LED_W + STEP_W + 3;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mode_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_seq_ctrl_if #(.LED_W(LED_W), .STEP_W(STEP_W)) bus ();

  led_seq_ctrl #(
    .CLK_DIV(CLK_DIV), .DWELL_TICKS(DWELL_TICKS), .DEB_TICKS(DEB_TICKS),
    .BLINK_TICKS(BLINK_TICKS), .NUM_STEPS(NUM_STEPS), .LED_W(LED_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total    = 0;
  int bad      = 0;
  int dut_evts = 0;

  // reference model: time measured in edges and ticks, steps derived arithmetically
  int    m_n;
  logic  m_kq[$];
  logic  m_level;
  int    m_drun;
  mode_t m_mode;
  int    m_run_ticks;
  int    m_pause_ticks;
  logic  m_last_tick;
  logic [OW-1:0] exp_q[$];

  function automatic int m_step();
    return (m_run_ticks / DWELL_TICKS) % NUM_STEPS;
  endfunction

  function automatic int m_dwell();
    return m_run_ticks % DWELL_TICKS;
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_kq = {1'b0, 1'b0};
    m_level = 1'b0;
    m_drun = 0;
    m_mode = M_IDLE;
    m_run_ticks = 0;
    m_pause_ticks = 0;
    m_last_tick = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic en_v, input logic key_v);
    logic tick, sk, accept, lit;
    int led_v;
    tick   = ((m_n % CLK_DIV) == CLK_DIV - 1);
    sk     = m_kq[0];
    accept = 1'b0;
    lit    = (m_mode == M_RUN) || (m_mode == M_PAUSE && ((m_pause_ticks / BLINK_TICKS) % 2 == 0));
    led_v  = lit ? m_step() : 0;
    if (tick) begin
      if (sk != m_level) begin
        if (m_drun + 1 == DEB_TICKS) begin
          m_level = sk;
          m_drun  = 0;
          accept  = sk;
        end else begin
          m_drun++;
        end
      end else begin
        m_drun = 0;
      end
    end
    exp_q.push_back({LED_W'(led_v), STEP_W'(m_step()), m_mode == M_RUN, m_mode == M_PAUSE, accept});
    if (!en_v) begin
      m_mode = M_IDLE;
      m_run_ticks = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (accept) begin m_mode = M_RUN; m_run_ticks = 0; end
        M_RUN: begin
          if (tick) m_run_ticks++;
          if (accept) begin m_mode = M_PAUSE; m_pause_ticks = 0; end
        end
        default: begin
          if (accept) m_mode = M_RUN;
          else if (tick) m_pause_ticks++;
        end
      endcase
    end
    m_n++;
    void'(m_kq.pop_front());
    m_kq.push_back(key_v);
    m_last_tick = tick;
  endtask

  // scoreboard
  task automatic check_out();
    logic [OW-1:0] obs, e;
    obs = {bus.led, bus.step_idx, bus.busy, bus.paused, bus.key_evt};
    e = exp_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL cycle n=%0d obs=%b exp=%b", m_n, obs, e);
    end
    if (bus.key_evt === 1'b1) dut_evts++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, e);
    end
  endtask

  // drivers: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic cyc(input logic en_v, input logic key_v);
    bus.en  = en_v;
    bus.key = key_v;
    @(posedge clk);
    model_edge(en_v, key_v);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic hold(input logic en_v, input logic key_v, input int n);
    for (int i = 0; i < n; i++) cyc(en_v, key_v);
  endtask

  task automatic wait_run(input int s, input int d, input string tag);
    int k;
    k = 0;
    while (!(m_mode == M_RUN && m_step() == s && m_dwell() == d && m_last_tick) && k < 200) begin
      cyc(1'b1, 1'b0);
      k++;
    end
    total++;
    assert (k < 200) else begin
      bad++;
      $error("FAIL %s_timeout obs=%0d exp=<200", tag, k);
    end
  endtask

  initial begin
    int c1, c2;
    logic seen;
    bus.en  = 1'b1;
    bus.key = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {bus.led, bus.step_idx, bus.busy, bus.paused, bus.key_evt}, 0);
    rst_n = 1'b1;
    model_reset();

    // start and stepping
    dut_evts = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, (i < 20));
      if (bus.led === 3'd1) c1++;
      if (bus.led === 3'd2) c2++;
      if (i == 19) begin
        chk("start_evts", dut_evts, 1);
        chk("start_busy", bus.busy, 1);
      end
    end
    chk("led1_len", c1, 12);
    chk("led2_len", c2, 12);

    // pause at step 2, blink, resume
    wait_run(2, 0, "to_step2");
    hold(1'b1, 1'b1, 12);
    chk("pause_paused", bus.paused, 1);
    chk("pause_step", bus.step_idx, 2);
    hold(1'b1, 1'b0, 32);
    hold(1'b1, 1'b1, 16);
    chk("resume_busy", bus.busy, 1);
    chk("resume_step", bus.step_idx, 3);
    hold(1'b1, 1'b0, 16);

    // press accepted on the same tick as a dwell expiry
    wait_run(1, 1, "to_step1");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1);
      if (bus.paused === 1'b1 && !seen) begin
        seen = 1'b1;
        chk("coll_step", bus.step_idx, 2);
      end
    end
    chk("coll_seen", seen, 1);
    hold(1'b1, 1'b0, 16);

    // enable drop at step 3, press ignored while disabled
    hold(1'b1, 1'b1, 12);
    hold(1'b1, 1'b0, 16);
    wait_run(3, 0, "to_step3");
    hold(1'b0, 1'b0, 2);
    chk("endrop_outs", {bus.led, bus.step_idx, bus.busy, bus.paused}, 0);
    hold(1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 16);
    chk("endis_idle", {bus.busy, bus.paused}, 0);

    // glitch shorter than the debounce window
    dut_evts = 0;
    hold(1'b1, 1'b1, 3);
    hold(1'b1, 1'b0, 20);
    chk("glitch_evts", dut_evts, 0);
    chk("glitch_idle", {bus.led, bus.busy}, 0);
    hold(1'b1, 1'b1, 12);
    chk("restart_busy", bus.busy, 1);
    chk("restart_step", bus.step_idx, 0);
    hold(1'b1, 1'b0, 16);

    // asynchronous reset mid-run with key held through release
    bus.en = 1'b1;
    bus.key = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("midrst_outs", {bus.led, bus.step_idx, bus.busy, bus.paused, bus.key_evt}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dut_evts = 0;
    hold(1'b1, 1'b1, 7);
    chk("midrst_noevt", dut_evts, 0);
    cyc(1'b1, 1'b1);
    chk("midrst_evt", bus.key_evt, 1);
    hold(1'b1, 1'b1, 4);
    hold(1'b1, 1'b0, 16);

    // random key and enable traffic
    begin
      int left;
      left = 2500;
      while (left > 0) begin
        int len;
        logic kv, ev;
        len = $urandom_range(1, 30);
        kv  = 1'($urandom_range(0, 1));
        ev  = ($urandom_range(0, 15) != 0);
        hold(ev, kv, len);
        left -= len;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
